// File: rtl/ft245_uart_pkg.sv
// rtl/ft245_uart_pkg.sv - shared UART state type and default parameters for the FT245 bridge
package ft245_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_t;

  localparam int DIV_DEFAULT   = 26;
  localparam int DEPTH_DEFAULT = 16;
  localparam int CNT_W         = 12;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers and a combinational head
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same clock frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ft245_uart_bridge.sv
// rtl/ft245_uart_bridge.sv - FT245-style CPU FIFO port over a UART; FT245_UART_BRIDGE_LOOPBACK_EN feeds TX back into RX
module ft245_uart_bridge
  import ft245_uart_pkg::*;
#(
  parameter int DIV   = DIV_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       rd_n,
  input  logic       wr,
  output logic       rdf_n,
  output logic       txe_n,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_overrun
);

  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(DIV / 2 - 1);

  logic rd_s1, rd_s2, rd_d;
  logic wr_s1, wr_s2, wr_d;
  logic rx_s1, rx_s2, rx_d;
  logic rx_line;
  logic [7:0] hold;
  logic cpu_pop, cpu_push;

  logic tx_full, tx_empty, tx_pop, tx_bit_end;
  logic rx_full, rx_empty, rx_push, rx_bit_end;
  logic [7:0] tx_head, rx_head;

  uart_state_t      tx_state, rx_state;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_bit, rx_bit;
  logic [7:0]       tx_sh, rx_sh;

  always_ff @(posedge clk) begin
    if (reset) begin
      {rd_s1, rd_s2, rd_d} <= 3'b111;
      {wr_s1, wr_s2, wr_d} <= 3'b000;
      {rx_s1, rx_s2, rx_d} <= 3'b111;
      hold <= 8'h00;
    end else begin
      {rd_s1, rd_s2, rd_d} <= {rd_n, rd_s1, rd_s2};
      {wr_s1, wr_s2, wr_d} <= {wr, wr_s1, wr_s2};
      {rx_s1, rx_s2}       <= {uart_rx, rx_s1};
      rx_d                 <= rx_line;
      if (wr_s2) hold <= d_in;
    end
  end

`ifdef FT245_UART_BRIDGE_LOOPBACK_EN
  assign rx_line = uart_tx;
`else
  assign rx_line = rx_s2;
`endif

  assign cpu_pop  = rd_s2 && !rd_d;
  assign cpu_push = !wr_s2 && wr_d;
  assign d_oe     = !rd_n;
  assign d_out    = rx_empty ? 8'h00 : rx_head;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(cpu_push), .push_data(hold),
    .pop(tx_pop), .head(tx_head), .full(tx_full), .empty(tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_sh),
    .pop(cpu_pop), .head(rx_head), .full(rx_full), .empty(rx_empty)
  );

  assign tx_bit_end = (tx_cnt == BIT_END);
  // The last STOP clock reloads directly so consecutive frames have no idle gap.
  assign tx_pop = !tx_empty && ((tx_state == ST_IDLE) || (tx_state == ST_STOP && tx_bit_end));

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= 8'h00;
      uart_tx  <= 1'b1;
    end else begin
      uart_tx <= (tx_state == ST_START) ? 1'b0 : (tx_state == ST_DATA) ? tx_sh[0] : 1'b1;
      if (tx_pop) begin
        tx_state <= ST_START;
        tx_sh    <= tx_head;
        tx_cnt   <= '0;
      end else begin
        case (tx_state)
          ST_START: begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
            if (tx_bit_end) begin
              tx_state <= ST_DATA;
              tx_bit   <= '0;
            end
          end
          ST_DATA: begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
            if (tx_bit_end) begin
              tx_sh  <= {1'b0, tx_sh[7:1]};
              tx_bit <= tx_bit + 1'b1;
              if (tx_bit == 3'd7) tx_state <= ST_STOP;
            end
          end
          ST_STOP: begin
            tx_cnt <= tx_bit_end ? '0 : tx_cnt + 1'b1;
            if (tx_bit_end) tx_state <= ST_IDLE;
          end
          default: tx_cnt <= '0;
        endcase
      end
    end
  end

  assign rx_bit_end = (rx_cnt == BIT_END);
  assign rx_push    = (rx_state == ST_STOP) && rx_bit_end && rx_line;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_sh      <= 8'h00;
      rx_overrun <= 1'b0;
      rdf_n      <= 1'b1;
      txe_n      <= 1'b0;
    end else begin
      rdf_n <= rx_empty;
      txe_n <= tx_full;
      if (rx_push && rx_full && !cpu_pop) rx_overrun <= 1'b1;
      case (rx_state)
        ST_IDLE: begin
          rx_cnt <= '0;
          if (rx_d && !rx_line) rx_state <= ST_START;
        end
        ST_START: begin
          // Half a bit in: a line already back high was only a glitch.
          if (rx_cnt == HALF_END) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_line ? ST_IDLE : ST_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          rx_cnt <= rx_bit_end ? '0 : rx_cnt + 1'b1;
          if (rx_bit_end) begin
            rx_sh  <= {rx_line, rx_sh[7:1]};
            rx_bit <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= ST_STOP;
          end
        end
        default: begin
          rx_cnt <= rx_bit_end ? '0 : rx_cnt + 1'b1;
          if (rx_bit_end) rx_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
